nexys_starship_lanes: RTL and testbench

NEXYS_STARSHIP_LANES -- requirements
Module: nexys_starship_lanes

---
 rtl/nexys_starship_lanes.sv | 152 +++++++++++++++
 tb/tb_nexys_starship_lanes.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nexys_starship_lanes.sv
// Starship lane game: a one-hot IDLE/PLAY/OVER controller over LANES independent
// EMPTY/ARMED/FULL monster lanes, with a shared occupancy cap and a saturating kill score.
module nexys_starship_lanes #(
  parameter int LANES       = 4,
  parameter int TIMER_W     = 8,
  parameter int TIMEOUT     = 12,
  parameter int SPAWN_DELAY = 1,
  parameter int MAX_ACTIVE  = 2
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             timer_tick,
  input  logic             play,
  input  logic             restart,
  input  logic [LANES-1:0] spawn_random,
  input  logic [LANES-1:0] kill,
  output logic [LANES-1:0] monster,
  output logic             gameover,
  output logic             q_Idle,
  output logic             q_Play,
  output logic             q_Over,
  output logic [7:0]       score
);

  typedef enum logic [2:0] {S_IDLE = 3'b001, S_PLAY = 3'b010, S_OVER = 3'b100} top_e;
  typedef enum logic [1:0] {L_EMPTY, L_ARMED, L_FULL} lane_e;

  localparam logic [TIMER_W-1:0] CNT_ONE    = TIMER_W'(1);
  localparam logic [TIMER_W-1:0] DELAY_MAX  = '1;
  localparam logic [TIMER_W-1:0] SPAWN_D    = TIMER_W'(SPAWN_DELAY);
  localparam logic [TIMER_W-1:0] TIMEOUT_C  = TIMER_W'(TIMEOUT);
  localparam logic [TIMER_W-1:0] TIMEOUT_M1 = TIMER_W'(TIMEOUT - 1);
  localparam logic [3:0]         MAX_ACT    = 4'(MAX_ACTIVE);

  top_e               r_state;
  lane_e              r_lane [LANES];
  logic [TIMER_W-1:0] r_cnt  [LANES];
  logic [LANES-1:0]   r_monster;
  logic [7:0]         r_score;

  lane_e              w_lane_nxt [LANES];
  logic [TIMER_W-1:0] w_cnt_nxt  [LANES];
  logic [LANES-1:0]   w_hit;
  logic [3:0]         w_used;
  logic [3:0]         w_nkill;
  logic [8:0]         w_score_sum;
  logic [7:0]         w_score_nxt;
  logic               w_over;
  logic               w_run;

  // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_hit   = '0;
    w_used  = '0;
    w_nkill = '0;
    for (int i = 0; i < LANES; i++) begin
      if (r_lane[i] == L_FULL) w_used = w_used + 4'd1;
    end
    // w_used grows as grants are handed out, so lower indices win the remaining slots.
    for (int i = 0; i < LANES; i++) begin
      w_lane_nxt[i] = r_lane[i];
      w_cnt_nxt[i]  = r_cnt[i];
      case (r_lane[i])
        L_EMPTY: begin
          if (r_cnt[i] >= SPAWN_D) begin
            w_lane_nxt[i] = L_ARMED;
            w_cnt_nxt[i]  = '0;
          end else if (timer_tick && r_cnt[i] != DELAY_MAX) begin
            w_cnt_nxt[i] = r_cnt[i] + CNT_ONE;
          end
        end
        L_ARMED: begin
          if (spawn_random[i] && w_used < MAX_ACT) begin
            w_used        = w_used + 4'd1;
            w_lane_nxt[i] = L_FULL;
            w_cnt_nxt[i]  = '0;
          end
        end
        L_FULL: begin
          if (kill[i]) begin
            w_nkill       = w_nkill + 4'd1;
            w_lane_nxt[i] = L_EMPTY;
            w_cnt_nxt[i]  = '0;
          end else begin
            if (timer_tick && r_cnt[i] < TIMEOUT_C) w_cnt_nxt[i] = r_cnt[i] + CNT_ONE;
            w_hit[i] = (r_cnt[i] >= TIMEOUT_C) || (timer_tick && r_cnt[i] >= TIMEOUT_M1);
          end
        end
        default: begin
          w_lane_nxt[i] = L_EMPTY;
          w_cnt_nxt[i]  = '0;
        end
      endcase
    end
    w_score_sum = {1'b0, r_score} + 9'(w_nkill);
    w_score_nxt = w_score_sum[8] ? 8'hFF : w_score_sum[7:0];
    w_over      = (r_state == S_PLAY) && (|w_hit);
    w_run       = (r_state == S_PLAY) && !w_over;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= S_IDLE;
      r_score <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (play) begin
          r_state <= S_PLAY;
          r_score <= '0;
        end
        S_PLAY: begin
          if (w_over) r_state <= S_OVER;
          else        r_score <= w_score_nxt;
        end
        S_OVER: if (restart) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Lanes only evolve while playing; any other state (including the game-over edge) empties them.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_monster <= '0;
      for (int i = 0; i < LANES; i++) begin
        r_lane[i] <= L_EMPTY;
        r_cnt[i]  <= '0;
      end
    end else if (w_run) begin
      for (int i = 0; i < LANES; i++) begin
        r_lane[i]    <= w_lane_nxt[i];
        r_cnt[i]     <= w_cnt_nxt[i];
        r_monster[i] <= (w_lane_nxt[i] == L_FULL);
      end
    end else begin
      r_monster <= '0;
      for (int i = 0; i < LANES; i++) begin
        r_lane[i] <= L_EMPTY;
        r_cnt[i]  <= '0;
      end
    end
  end

  assign monster  = r_monster;
  assign score    = r_score;
  assign q_Idle   = r_state[0];
  assign q_Play   = r_state[1];
  assign q_Over   = r_state[2];
  assign gameover = r_state[2];

endmodule

// File: tb/tb_nexys_starship_lanes.sv
// Scoreboard bench: two lane-game instances (occupancy caps 2 and 3) on shared inputs,
// checked every cycle against a per-lane integer model of the game rules.
module tb_nexys_starship_lanes;
  localparam int LANES       = 4;
  localparam int TIMEOUT     = 12;
  localparam int SPAWN_DELAY = 1;

  logic             Clk = 1'b0;
  logic             Reset_n = 1'b0;
  logic             timer_tick = 1'b0;
  logic             play = 1'b0;
  logic             restart = 1'b0;
  logic [LANES-1:0] spawn_random = '0;
  logic [LANES-1:0] kill = '0;

  logic [LANES-1:0] mon [2];
  logic             go [2];
  logic             qi [2];
  logic             qp [2];
  logic             qo [2];
  logic [7:0]       sc [2];

  nexys_starship_lanes #(.LANES(LANES), .TIMER_W(8), .TIMEOUT(TIMEOUT),
                         .SPAWN_DELAY(SPAWN_DELAY), .MAX_ACTIVE(2)) u0 (
    .Clk(Clk), .Reset_n(Reset_n), .timer_tick(timer_tick), .play(play), .restart(restart),
    .spawn_random(spawn_random), .kill(kill), .monster(mon[0]), .gameover(go[0]),
    .q_Idle(qi[0]), .q_Play(qp[0]), .q_Over(qo[0]), .score(sc[0]));

  nexys_starship_lanes #(.LANES(LANES), .TIMER_W(8), .TIMEOUT(TIMEOUT),
                         .SPAWN_DELAY(SPAWN_DELAY), .MAX_ACTIVE(3)) u1 (
    .Clk(Clk), .Reset_n(Reset_n), .timer_tick(timer_tick), .play(play), .restart(restart),
    .spawn_random(spawn_random), .kill(kill), .monster(mon[1]), .gameover(go[1]),
    .q_Idle(qi[1]), .q_Play(qp[1]), .q_Over(qo[1]), .score(sc[1]));

  always #5 Clk = ~Clk;

  int n_total = 0;
  int n_bad   = 0;

  // Model: mode 0 idle, 1 play, 2 over; phase 0 empty, 1 armed, 2 full.
  int m_mode  [2];
  int m_phase [2][LANES];
  int m_cnt   [2][LANES];
  int m_score [2];

  logic [31:0] sb_q [$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic int max_act(input int k);
    return (k == 0) ? 2 : 3;
  endfunction

  function automatic logic [15:0] dut_out(input int k);
    return {mon[k], go[k], qi[k], qp[k], qo[k], sc[k]};
  endfunction

  function automatic logic [15:0] model_out(input int k);
    logic [3:0] m;
    m = '0;
    for (int i = 0; i < LANES; i++) m[i] = (m_phase[k][i] == 2);
    return {m, m_mode[k] == 2, m_mode[k] == 0, m_mode[k] == 1, m_mode[k] == 2, 8'(m_score[k])};
  endfunction

  function automatic logic [3:0] full_mask(input int k);
    logic [3:0] m;
    m = '0;
    for (int i = 0; i < LANES; i++) m[i] = (m_phase[k][i] == 2);
    return m;
  endfunction

  task automatic clear_lanes(input int k);
    for (int i = 0; i < LANES; i++) begin
      m_phase[k][i] = 0;
      m_cnt[k][i]   = 0;
    end
  endtask

  task automatic model_step(input int k, input bit rst, input bit pl, input bit rs, input bit tk,
                            input logic [3:0] sp, input logic [3:0] kl);
    int  room;
    int  kills;
    bit  over;
    if (!rst) begin
      m_mode[k]  = 0;
      m_score[k] = 0;
      clear_lanes(k);
      return;
    end
    case (m_mode[k])
      0: if (pl) begin
        m_mode[k]  = 1;
        m_score[k] = 0;
      end
      1: begin
        room  = max_act(k) - $countones(full_mask(k));
        kills = 0;
        over  = 0;
        for (int i = 0; i < LANES; i++) begin
          if (m_phase[k][i] == 0) begin
            if (m_cnt[k][i] >= SPAWN_DELAY) begin
              m_phase[k][i] = 1;
              m_cnt[k][i]   = 0;
            end else if (tk && m_cnt[k][i] < 255) m_cnt[k][i]++;
          end else if (m_phase[k][i] == 1) begin
            if (sp[i] && room > 0) begin
              m_phase[k][i] = 2;
              m_cnt[k][i]   = 0;
              room--;
            end
          end else begin
            if (kl[i]) begin
              kills++;
              m_phase[k][i] = 0;
              m_cnt[k][i]   = 0;
            end else begin
              if (tk && m_cnt[k][i] < TIMEOUT) m_cnt[k][i]++;
              if (m_cnt[k][i] >= TIMEOUT) over = 1;
            end
          end
        end
        if (over) begin
          m_mode[k] = 2;
          clear_lanes(k);
        end else begin
          m_score[k] = (m_score[k] + kills > 255) ? 255 : m_score[k] + kills;
        end
      end
      default: if (rs) m_mode[k] = 0;
    endcase
  endtask

  // Drive one cycle of inputs at the falling edge and queue the response expected after the next rise.
  task automatic cycle(input bit rst, input bit pl, input bit rs, input bit tk,
                       input logic [3:0] sp, input logic [3:0] kl);
    @(negedge Clk);
    Reset_n      = rst;
    play         = pl;
    restart      = rs;
    timer_tick   = tk;
    spawn_random = sp;
    kill         = kl;
    for (int k = 0; k < 2; k++) model_step(k, rst, pl, rs, tk, sp, kl);
    sb_q.push_back({model_out(0), model_out(1)});
    if (!rst) begin
      #1;
      for (int k = 0; k < 2; k++) check("async_reset", dut_out(k), model_out(k));
    end
  endtask

  task automatic after_edge();
    @(posedge Clk);
    #2;
  endtask

  initial begin : monitor
    logic [31:0] e;
    forever begin
      @(posedge Clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("sb_u0", dut_out(0), e[31:16]);
        check("sb_u1", dut_out(1), e[15:0]);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "bench timeout");
  end

  initial begin : driver
    logic [3:0] km;
    int         room;
    for (int k = 0; k < 2; k++) begin
      m_mode[k]  = 0;
      m_score[k] = 0;
      clear_lanes(k);
    end

    repeat (3) cycle(0, 0, 0, 0, 4'h0, 4'h0);
    after_edge();
    check("reset_idle", {qi[0], qp[0], qo[0]}, 3'b100);
    check("reset_score", sc[0], 8'd0);

    // Arm after one tick, then spawn lane 0.
    cycle(1, 1, 0, 0, 4'h0, 4'h0);
    cycle(1, 0, 0, 1, 4'h1, 4'h0);
    cycle(1, 0, 0, 0, 4'h1, 4'h0);
    cycle(1, 0, 0, 0, 4'h1, 4'h0);
    after_edge();
    check("spawn_lane0", mon[0], 4'b0001);

    // Lane 0 survives eleven ticks, dies on the twelfth.
    repeat (11) cycle(1, 0, 0, 1, 4'h0, 4'h0);
    after_edge();
    check("tick11_alive", {go[0], mon[0]}, 5'b0_0001);
    cycle(1, 0, 0, 1, 4'h0, 4'h0);
    after_edge();
    check("tick12_over", {go[0], qo[0], mon[0]}, 6'b11_0000);
    cycle(1, 0, 1, 0, 4'h0, 4'h0);
    after_edge();
    check("restart_idle", qi[0], 1'b1);

    // Simultaneous spawn on four armed lanes against the occupancy cap.
    cycle(1, 1, 0, 0, 4'h0, 4'h0);
    cycle(1, 0, 0, 1, 4'h0, 4'h0);
    cycle(1, 0, 0, 0, 4'h0, 4'h0);
    cycle(1, 0, 0, 0, 4'hF, 4'h0);
    after_edge();
    check("grant_cap2", mon[0], 4'b0011);
    check("grant_cap3", mon[1], 4'b0111);
    cycle(1, 0, 0, 0, 4'b0100, 4'b0001);
    after_edge();
    check("kill_free_late", mon[0], 4'b0010);
    cycle(1, 0, 0, 0, 4'b0100, 4'h0);
    after_edge();
    check("grant_next_cycle", mon[0], 4'b0110);

    // Kill beats timeout on the same tick.
    repeat (11) cycle(1, 0, 0, 1, 4'h0, 4'h0);
    cycle(1, 0, 0, 1, 4'h0, 4'b0110);
    after_edge();
    check("kill_wins", {go[0], qp[0], mon[0]}, 6'b01_0000);
    check("kill_score", sc[0], 8'd3);

    // Two monsters live, then asynchronous reset.
    cycle(1, 0, 0, 0, 4'hF, 4'h0);
    after_edge();
    check("two_live", mon[0], 4'b1001);
    cycle(0, 0, 0, 0, 4'h0, 4'h0);
    cycle(0, 0, 0, 0, 4'h0, 4'h0);

    // Climb instance 1 to 254, then a triple kill saturates.
    cycle(1, 1, 0, 0, 4'h0, 4'h0);
    for (int n = 0; n < 2000 && m_score[1] < 254; n++) begin
      km   = '0;
      room = 254 - m_score[1];
      for (int i = 0; i < LANES; i++) begin
        if (m_phase[1][i] == 2 && room > 0) begin
          km[i] = 1'b1;
          room--;
        end
      end
      cycle(1, 0, 0, 1, 4'hF, km);
    end
    after_edge();
    check("score_254", sc[1], 8'd254);
    for (int n = 0; n < 10 && $countones(full_mask(1)) < 3; n++) cycle(1, 0, 0, 1, 4'hF, 4'h0);
    after_edge();
    check("three_full", 32'($countones(mon[1])), 32'd3);
    cycle(1, 0, 0, 1, 4'hF, full_mask(1));
    after_edge();
    check("score_sat", sc[1], 8'd255);
    for (int n = 0; n < 8; n++) cycle(1, 0, 0, 1, 4'hF, full_mask(1));
    after_edge();
    check("score_stays", sc[1], 8'd255);

    // Randomized play.
    cycle(0, 0, 0, 0, 4'h0, 4'h0);
    for (int n = 0; n < 2500; n++) begin
      cycle($urandom_range(0, 149) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 1) == 1, 4'($urandom), 4'($urandom & $urandom & $urandom));
    end

    after_edge();
    after_edge();
    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
